avalon_pwm_multi: RTL and testbench



---
 rtl/avalon_pwm_multi.sv | 175 +++++++++++++++++
 tb/tb_avalon_pwm_multi.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM generator with an Avalon-MM register interface.
// Period and compare values are double-buffered and load into the counter path at period wrap.
module avalon_pwm_multi #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               csi_clk,
  input  logic               csi_reset_n,
  input  logic               avs_chipselect,
  input  logic [3:0]         avs_address,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic               ins_irq,
  output logic [N_CH-1:0]    coe_PWM_OUT
);

  typedef enum logic [3:0] {
    REG_CTRL     = 4'd0,
    REG_PRESCALE = 4'd1,
    REG_PERIOD   = 4'd2,
    REG_STATUS   = 4'd3,
    REG_POL      = 4'd12,
    REG_CH_EN    = 4'd13
  } reg_addr_e;

  localparam logic [PRESC_W-1:0] PRESC_RST  = PRESC_W'(99);
  localparam logic [CNT_W-1:0]   PERIOD_RST = CNT_W'(999);

  logic                 en;
  logic                 irq_en;
  logic [PRESC_W-1:0]   prescale;
  logic [PRESC_W-1:0]   presc_cnt;
  logic [CNT_W-1:0]     period_sh;
  logic [CNT_W-1:0]     period_act;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cmp_sh  [N_CH];
  logic [CNT_W-1:0]     cmp_act [N_CH];
  logic [N_CH-1:0]      pol;
  logic [N_CH-1:0]      ch_en;
  logic                 done;

  logic                 wr_en;
  logic                 rd_en;
  logic                 tick;
  logic                 wrap;
  logic [N_CH-1:0]      cmp_wr;
  logic [N_CH-1:0]      active;
  logic [31:0]          rdata_n;
  logic                 unused_wdata;

  assign wr_en        = avs_chipselect & avs_write;
  assign rd_en        = avs_chipselect & avs_read & ~avs_write;
  assign tick         = en & (presc_cnt == prescale);
  assign wrap         = tick & (cnt == period_act);
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    cmp_wr = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      cmp_wr[i] = wr_en & (avs_address == 4'(4 + i));
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      prescale  <= PRESC_RST;
      period_sh <= PERIOD_RST;
      pol       <= '0;
      ch_en     <= '1;
    end else if (wr_en) begin
      case (avs_address)
        REG_CTRL:     {irq_en, en} <= avs_writedata[1:0];
        REG_PRESCALE: prescale     <= avs_writedata[PRESC_W-1:0];
        REG_PERIOD:   period_sh    <= avs_writedata[CNT_W-1:0];
        REG_POL:      pol          <= avs_writedata[N_CH-1:0];
        REG_CH_EN:    ch_en        <= avs_writedata[N_CH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      for (int unsigned i = 0; i < N_CH; i++)
        cmp_sh[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (cmp_wr[i]) cmp_sh[i] <= avs_writedata[CNT_W-1:0];
    end
  end

  // While disabled the active copies follow the shadows so enabling starts from fresh values.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      presc_cnt  <= '0;
      cnt        <= '0;
      period_act <= PERIOD_RST;
      for (int unsigned i = 0; i < N_CH; i++)
        cmp_act[i] <= '0;
    end else if (!en) begin
      presc_cnt  <= '0;
      cnt        <= '0;
      period_act <= period_sh;
      for (int unsigned i = 0; i < N_CH; i++)
        cmp_act[i] <= cmp_sh[i];
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      if (wrap) begin
        cnt        <= '0;
        period_act <= period_sh;
        for (int unsigned i = 0; i < N_CH; i++)
          cmp_act[i] <= cmp_sh[i];
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n)
      done <= 1'b0;
    else if (wrap)
      done <= 1'b1;
    else if (wr_en && (avs_address == REG_STATUS) && avs_writedata[0])
      done <= 1'b0;
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      active[i] = en & ch_en[i] & (cnt < cmp_act[i]);
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      coe_PWM_OUT <= '1;
      ins_irq     <= 1'b0;
    end else begin
      coe_PWM_OUT <= ~(active ^ pol);
      ins_irq     <= done & irq_en;
    end
  end

  // Counter field of STATUS sits in bits [CNT_W+15:16]; CNT_W is limited to 16 for it to fit.
  always_comb begin
    rdata_n = '0;
    case (avs_address)
      REG_CTRL:     rdata_n[1:0]         = {irq_en, en};
      REG_PRESCALE: rdata_n[PRESC_W-1:0] = prescale;
      REG_PERIOD:   rdata_n[CNT_W-1:0]   = period_sh;
      REG_STATUS: begin
        rdata_n[0]             = done;
        rdata_n[CNT_W+15:16]   = cnt;
      end
      REG_POL:      rdata_n[N_CH-1:0]    = pol;
      REG_CH_EN:    rdata_n[N_CH-1:0]    = ch_en;
      default: begin
        for (int unsigned i = 0; i < N_CH; i++)
          if (avs_address == 4'(4 + i)) rdata_n[CNT_W-1:0] = cmp_sh[i];
      end
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n)
      avs_readdata <= '0;
    else if (rd_en)
      avs_readdata <= rdata_n;
  end

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Self-checking bench for avalon_pwm_multi: period-phase model checked every cycle plus directed literal checks.
module tb_avalon_pwm_multi;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs    = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [3:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic [3:0]  pwm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avalon_pwm_multi #(.N_CH(4), .CNT_W(16), .PRESC_W(8)) dut (
    .csi_clk        (clk),
    .csi_reset_n    (rst_n),
    .avs_chipselect (cs),
    .avs_address    (addr),
    .avs_read       (rd),
    .avs_readdata   (rdata),
    .avs_write      (wr),
    .avs_writedata  (wdata),
    .ins_irq        (irq),
    .coe_PWM_OUT    (pwm)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time is tracked as clocks elapsed inside the current period (phase).
  bit          m_en, m_irq_en, m_done, m_irq;
  int          m_ps, m_per, m_per_act, m_phase;
  int          m_cmp [4];
  int          m_cmp_act [4];
  logic [3:0]  m_pol, m_chen, m_out;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_reg(input logic [3:0] a);
    case (a)
      4'd0:                   return {30'd0, m_irq_en, m_en};
      4'd1:                   return 32'(m_ps);
      4'd2:                   return 32'(m_per);
      4'd3:                   return (32'(m_phase / (m_ps + 1)) << 16) | 32'(m_done);
      4'd4, 4'd5, 4'd6, 4'd7: return 32'(m_cmp[a - 4'd4]);
      4'd12:                  return {28'd0, m_pol};
      4'd13:                  return {28'd0, m_chen};
      default:                return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= 0; m_irq_en <= 0; m_done <= 0; m_irq <= 0;
      m_ps <= 99; m_per <= 999; m_per_act <= 999; m_phase <= 0;
      for (int i = 0; i < 4; i++) begin m_cmp[i] <= 0; m_cmp_act[i] <= 0; end
      m_pol <= 4'h0; m_chen <= 4'hF; m_out <= 4'hF; m_rdata <= '0;
    end else begin
      automatic int  cur   = m_phase / (m_ps + 1);
      automatic int  len   = (m_per_act + 1) * (m_ps + 1);
      automatic bit  wrp   = m_en && (m_phase == len - 1);
      automatic bit  wr_s  = cs && wr;
      automatic bit  rd_s  = cs && rd && !wr;
      for (int i = 0; i < 4; i++)
        m_out[i] <= (m_en && m_chen[i] && (cur < m_cmp_act[i])) ? m_pol[i] : !m_pol[i];
      m_irq <= m_done && m_irq_en;
      if (rd_s) m_rdata <= m_reg(addr);
      if (!m_en || wrp) begin
        m_per_act <= m_per;
        for (int i = 0; i < 4; i++) m_cmp_act[i] <= m_cmp[i];
      end
      m_phase <= (m_en && !wrp) ? m_phase + 1 : 0;
      if (wrp) m_done <= 1;
      else if (wr_s && addr == 4'd3 && wdata[0]) m_done <= 0;
      if (wr_s) begin
        case (addr)
          4'd0:  begin m_en <= wdata[0]; m_irq_en <= wdata[1]; end
          4'd1:  m_ps  <= int'(wdata[7:0]);
          4'd2:  m_per <= int'(wdata[15:0]);
          4'd4, 4'd5, 4'd6, 4'd7: m_cmp[addr - 4'd4] <= int'(wdata[15:0]);
          4'd12: m_pol  <= wdata[3:0];
          4'd13: m_chen <= wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("pwm_vs_model", {28'd0, pwm}, {28'd0, m_out});
    check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
    check("rdata_vs_model", rdata, m_rdata);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    cs = 1; wr = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 0; wr = 0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    cs = 1; rd = 1; addr = a;
    @(posedge clk); #1;
    cs = 0; rd = 0;
    d = rdata;
  endtask

  logic [31:0] rst_exp [16] = '{32'd0, 32'd99, 32'd999, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hF, 32'd0, 32'd0};

  initial begin
    logic [31:0] d;
    logic [19:0] s;
    int          k;

    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    step(1);
    check("reset_pwm", {28'd0, pwm}, 32'hF);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    for (int a = 0; a < 16; a++) begin
      bus_rd(4'(a), d);
      check($sformatf("reset_reg%0d", a), d, rst_exp[a]);
    end

    bus_rd(4'd1, d);
    cs = 1; rd = 1; wr = 1; addr = 4'd15; wdata = '1;
    step(1);
    cs = 0; rd = 0; wr = 0;
    check("rd_wr_collision_holds", rdata, 32'd99);

    // 3/10 duty on channel 0, one tick per clock
    bus_wr(4'd1, 32'd0);
    bus_wr(4'd2, 32'd9);
    bus_wr(4'd4, 32'd3);
    bus_wr(4'd12, 32'd1);
    bus_wr(4'd0, 32'd1);
    for (int j = 0; j < 20; j++) begin step(1); s[j] = pwm[0]; end
    check("duty3_pattern", {12'd0, s}, 32'h01C07);
    check("duty3_other_channels", {29'd0, pwm[3:1]}, 32'h7);

    // compare change mid-period applies at the next wrap
    bus_wr(4'd4, 32'd7);
    bus_rd(4'd4, d);
    check("cmp0_readback", d, 32'd7);
    for (int j = 0; j < 20; j++) begin step(1); s[j] = pwm[0]; end
    check("duty_update_at_wrap", {12'd0, s}, 32'hC7F01);

    // 0% and 100% duty, then channel disable
    bus_wr(4'd5, 32'd0);
    bus_wr(4'd6, 32'd20);
    bus_wr(4'd12, 32'd7);
    step(10);
    k = 0;
    for (int j = 0; j < 10; j++) begin step(1); if (pwm[2:1] == 2'b10) k++; end
    check("ch1_low_ch2_high", k, 10);
    bus_wr(4'd13, 32'hB);
    check("chen_before", {31'd0, pwm[2]}, 32'd1);
    step(1);
    check("chen_after", {31'd0, pwm[2]}, 32'd0);

    // interrupt after first wrap, set-wins on wrap-cycle W1C, later clear
    bus_wr(4'd3, 32'd1);
    bus_wr(4'd0, 32'd3);
    check("irq_low_before_wrap", {31'd0, irq}, 32'd0);
    k = 0;
    while (!irq && k < 15) begin step(1); k++; end
    check("irq_latency", k, 2);
    step(8);
    bus_wr(4'd3, 32'd1);
    bus_rd(4'd3, d);
    check("done_set_wins", {31'd0, d[0]}, 32'd1);
    check("irq_still_high", {31'd0, irq}, 32'd1);
    bus_wr(4'd3, 32'd1);
    check("irq_hold_one_cycle", {31'd0, irq}, 32'd1);
    step(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // asynchronous reset mid-count
    #2 rst_n = 0;
    #1;
    check("async_reset_pwm", {28'd0, pwm}, 32'hF);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step(1);
    bus_rd(4'd3, d);
    check("post_reset_status", d, 32'd0);
    bus_rd(4'd0, d);
    check("post_reset_ctrl", d, 32'd0);

    // prescaler: 3 clocks per count, 4 counts per period, 2 counts active
    bus_wr(4'd1, 32'd2);
    bus_wr(4'd2, 32'd3);
    bus_wr(4'd7, 32'd2);
    bus_wr(4'd12, 32'h8);
    bus_wr(4'd0, 32'd1);
    step(5);
    k = 0;
    for (int j = 0; j < 24; j++) begin step(1); if (pwm[3]) k++; end
    check("presc_duty", k, 12);
    bus_rd(4'd3, d);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
